// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between instruction fetch (read-only) and the
// MEM stage (read/write with byte masks). Each access runs IDLE -> BUSY_x ->
// RESP, with mem_* driven from registers for the whole BUSY phase, a one-cycle
// done pulse in RESP, and an abort with err if the memory never acknowledges.
// Fetch is protected from starvation by a cap on consecutive data grants made
// while fetch is waiting.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    input  logic [3:0]  d_rmask,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_ce,
    output logic        mem_wr,
    output logic        mem_rr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic [3:0]  mem_rmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY_I,
        ST_BUSY_D,
        ST_RESP
    } state_t;

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);
    // The abort fires on the last allowed BUSY cycle so that exactly
    // ACK_TIMEOUT cycles of mem_ce are seen before done/err.
    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_reg;
    logic [3:0]  d_streak_reg;
    logic [7:0]  timeout_reg;
    logic        if_done_reg;
    logic        d_done_reg;
    logic        err_reg;
    logic [31:0] if_rdata_reg;
    logic [31:0] d_rdata_reg;
    logic        mem_ce_reg;
    logic        mem_wr_reg;
    logic        mem_rr_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [3:0]  mem_wmask_reg;
    logic [3:0]  mem_rmask_reg;

    logic        grant_d;
    logic        grant_i;
    logic        busy_end;

    // IDLE-cycle arbitration: data wins contention until its streak hits the cap
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (d_req && !(if_req && (d_streak_reg == STREAK_LIMIT))) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // An access ends on ack, or on the final timeout cycle without one
    assign busy_end = mem_ack || (timeout_reg == TIMEOUT_LAST);

    // Access sequencer: state, memory drive, completion pulses and read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            timeout_reg   <= '0;
            if_done_reg   <= 1'b0;
            d_done_reg    <= 1'b0;
            err_reg       <= 1'b0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
            mem_ce_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_rr_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wmask_reg <= '0;
            mem_rmask_reg <= '0;
        end else begin
            if_done_reg <= 1'b0;
            d_done_reg  <= 1'b0;
            err_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    timeout_reg <= '0;
                    if (grant_d) begin
                        state_reg     <= ST_BUSY_D;
                        mem_ce_reg    <= 1'b1;
                        mem_wr_reg    <= d_wr;
                        mem_rr_reg    <= ~d_wr;
                        mem_addr_reg  <= d_addr;
                        mem_wdata_reg <= d_wdata;
                        mem_wmask_reg <= d_wmask;
                        mem_rmask_reg <= d_rmask;
                    end else if (grant_i) begin
                        state_reg     <= ST_BUSY_I;
                        mem_ce_reg    <= 1'b1;
                        mem_wr_reg    <= 1'b0;
                        mem_rr_reg    <= 1'b1;
                        mem_addr_reg  <= if_addr;
                        mem_wdata_reg <= '0;
                        mem_wmask_reg <= 4'h0;
                        mem_rmask_reg <= 4'hF;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (busy_end) begin
                        state_reg     <= ST_RESP;
                        mem_ce_reg    <= 1'b0;
                        mem_wr_reg    <= 1'b0;
                        mem_rr_reg    <= 1'b0;
                        mem_addr_reg  <= '0;
                        mem_wdata_reg <= '0;
                        mem_wmask_reg <= '0;
                        mem_rmask_reg <= '0;
                        err_reg       <= ~mem_ack;
                        if (state_reg == ST_BUSY_I) begin
                            if_done_reg <= 1'b1;
                            if (mem_ack) begin
                                if_rdata_reg <= mem_rdata;
                            end
                        end else begin
                            d_done_reg <= 1'b1;
                            if (mem_ack && !mem_wr_reg) begin
                                d_rdata_reg <= mem_rdata;
                            end
                        end
                    end else begin
                        timeout_reg <= timeout_reg + 8'd1;
                    end
                end
                ST_RESP: begin
                    // No arbitration here: a request still held during its
                    // done cycle must not be issued a second time.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Fairness streak: counts data grants taken while fetch is waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_streak_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            if (!if_req || grant_i) begin
                d_streak_reg <= '0;
            end else if (grant_d) begin
                d_streak_reg <= d_streak_reg + 4'd1;
            end
        end
    end

    assign if_done   = if_done_reg;
    assign d_done    = d_done_reg;
    assign err       = err_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign mem_ce    = mem_ce_reg;
    assign mem_wr    = mem_wr_reg;
    assign mem_rr    = mem_rr_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wmask = mem_wmask_reg;
    assign mem_rmask = mem_rmask_reg;

    assign stall_if  = if_req & ~if_done_reg;
    assign stall_mem = d_req & ~d_done_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with a hand-driven
// memory, then a randomized phase against a word-level memory model and
// request-level expectations (data integrity, one access per request,
// bounded fetch waiting).
module tb_mem_port_arbiter;

    localparam int MAX_D_STREAK = 4;
    localparam int ACK_TIMEOUT  = 16;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [3:0]  d_rmask;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_ce;
    logic        mem_wr;
    logic        mem_rr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [3:0]  mem_rmask;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;

    int n_cmp = 0;
    int n_err = 0;

    // memory environment (responder) and reference contents
    logic        auto_mode;
    int          resp_cnt;
    int          resp_wait;
    int          max_wait;
    logic [31:0] mem_arr [0:63];
    logic [31:0] ref_mem [0:63];

    mem_port_arbiter #(
        .MAX_D_STREAK(MAX_D_STREAK),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wmask  (d_wmask),
        .d_rmask  (d_rmask),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .err      (err),
        .mem_ce   (mem_ce),
        .mem_wr   (mem_wr),
        .mem_rr   (mem_rr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rmask(mem_rmask),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .stall_if (stall_if),
        .stall_mem(stall_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] fpat(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0103);
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // advance one clock; sample point is 2 time units after the rising edge.
    // In auto mode, also act as the memory: ack after resp_wait extra cycles.
    task automatic step();
        int idx;
        @(posedge clk);
        #2;
        if (auto_mode) begin
            if (mem_ce) begin
                if (resp_cnt == 0) resp_wait = $urandom_range(0, max_wait);
                if (resp_cnt == resp_wait) begin
                    idx = int'(mem_addr[7:2]);
                    mem_ack = 1'b1;
                    if (mem_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wmask[b]) mem_arr[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = mem_arr[idx];
                    end
                end else begin
                    mem_ack = 1'b0;
                end
                resp_cnt++;
            end else begin
                mem_ack  = 1'b0;
                resp_cnt = 0;
            end
        end
    endtask

    initial begin
        int   ngr;
        int   exp_streak;
        logic got_f;
        logic exp_f;
        logic f_granted;
        logic d_granted;
        logic f_drop;
        logic d_drop;
        logic have_rd;
        logic [31:0] last_rd;
        int   dg;
        int   nf;
        int   nd;
        int   di;

        rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wr = 1'b0;
        d_addr = '0; d_wdata = '0; d_wmask = '0; d_rmask = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        auto_mode = 1'b0; resp_cnt = 0; resp_wait = 0; max_wait = 0;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = fpat(i);
            ref_mem[i] = fpat(i);
        end

        // ---- reset state ----
        repeat (2) step();
        chk1 ("rst_if_done", if_done, 1'b0);
        chk1 ("rst_d_done",  d_done,  1'b0);
        chk1 ("rst_err",     err,     1'b0);
        chk1 ("rst_mem_ce",  mem_ce,  1'b0);
        chk1 ("rst_mem_wr",  mem_wr,  1'b0);
        chk1 ("rst_mem_rr",  mem_rr,  1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_masks", {24'h0, mem_wmask, mem_rmask}, 32'h0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        rst = 1'b1;
        step();

        // ---- single fetch, zero wait ----
        if_req = 1'b1; if_addr = 32'h0000_0040;
        #1;
        chk1("t1_stall_if_c0", stall_if, 1'b1);
        step();
        chk1 ("t1_mem_ce", mem_ce, 1'b1);
        chk1 ("t1_mem_rr", mem_rr, 1'b1);
        chk1 ("t1_mem_wr", mem_wr, 1'b0);
        chk32("t1_mem_addr", mem_addr, 32'h40);
        chk32("t1_masks", {24'h0, mem_wmask, mem_rmask}, 32'h0000_000F);
        chk1 ("t1_done_c1", if_done, 1'b0);
        chk1 ("t1_stall_if_c1", stall_if, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h2402_0005;
        step();
        chk1 ("t1_if_done", if_done, 1'b1);
        chk32("t1_if_rdata", if_rdata, 32'h2402_0005);
        chk1 ("t1_err", err, 1'b0);
        chk1 ("t1_mem_ce_off", mem_ce, 1'b0);
        chk1 ("t1_stall_if_c2", stall_if, 1'b0);
        mem_ack = 1'b0; mem_rdata = 32'h0BAD_0BAD; if_req = 1'b0;
        step();
        chk1 ("t1_done_pulse", if_done, 1'b0);
        chk32("t1_rdata_hold", if_rdata, 32'h2402_0005);

        // ---- data write, 3 wait states ----
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h100; d_wdata = 32'hA5A5_A5A5;
        d_wmask = 4'b0011; d_rmask = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk1 ($sformatf("t2_mem_wr_c%0d", k), mem_wr, 1'b1);
            chk1 ($sformatf("t2_mem_rr_c%0d", k), mem_rr, 1'b0);
            chk32($sformatf("t2_wmask_c%0d", k), {28'h0, mem_wmask}, 32'h3);
            chk32($sformatf("t2_wdata_c%0d", k), mem_wdata, 32'hA5A5_A5A5);
            chk1 ($sformatf("t2_no_done_c%0d", k), d_done, 1'b0);
            if (k == 4) begin
                mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
            end
        end
        step();
        chk1 ("t2_d_done", d_done, 1'b1);
        chk32("t2_d_rdata_unchanged", d_rdata, 32'h0);
        chk1 ("t2_err", err, 1'b0);
        chk1 ("t2_mem_ce_off", mem_ce, 1'b0);
        mem_ack = 1'b0; d_req = 1'b0; d_wr = 1'b0; d_wmask = 4'h0;
        step();
        chk1 ("t2_done_pulse", d_done, 1'b0);

        // ---- request held through done: no second access ----
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h200; d_rmask = 4'hF;
        step();
        chk1 ("t3_mem_ce", mem_ce, 1'b1);
        chk32("t3_mem_addr", mem_addr, 32'h200);
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
        step();
        chk1 ("t3_d_done", d_done, 1'b1);
        chk32("t3_d_rdata", d_rdata, 32'h1122_3344);
        chk1 ("t3_stall_mem_done", stall_mem, 1'b0);
        mem_ack = 1'b0;
        step();
        chk1 ("t3_no_reissue", mem_ce, 1'b0);
        chk1 ("t3_done_once", d_done, 1'b0);
        d_req = 1'b0;
        step();
        chk1 ("t3_still_idle", mem_ce, 1'b0);

        // ---- timeout on a data read ----
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h300; d_rmask = 4'hF;
        mem_rdata = 32'hFFFF_0000;
        for (int k = 1; k <= ACK_TIMEOUT; k++) begin
            step();
            chk1($sformatf("t4_mem_ce_c%0d", k), mem_ce, 1'b1);
            chk1($sformatf("t4_no_done_c%0d", k), d_done, 1'b0);
        end
        step();
        chk1 ("t4_mem_ce_off", mem_ce, 1'b0);
        chk1 ("t4_d_done", d_done, 1'b1);
        chk1 ("t4_err", err, 1'b1);
        chk32("t4_d_rdata_kept", d_rdata, 32'h1122_3344);
        d_req = 1'b0;
        step();
        chk1 ("t4_err_pulse", err, 1'b0);
        chk1 ("t4_done_pulse", d_done, 1'b0);

        // ---- asynchronous reset in the middle of BUSY_D ----
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h400; d_rmask = 4'hF;
        step();
        chk1("t5_busy", mem_ce, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        chk1 ("t5_mem_ce", mem_ce, 1'b0);
        chk1 ("t5_mem_rr", mem_rr, 1'b0);
        chk32("t5_mem_addr", mem_addr, 32'h0);
        chk32("t5_d_rdata", d_rdata, 32'h0);
        chk32("t5_if_rdata", if_rdata, 32'h0);
        chk1 ("t5_d_done", d_done, 1'b0);
        chk1 ("t5_stall_mem", stall_mem, 1'b1);
        d_req = 1'b0;
        step();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h44;
        step();
        chk1 ("t5_fetch_ce", mem_ce, 1'b1);
        chk1 ("t5_fetch_rr", mem_rr, 1'b1);
        chk32("t5_fetch_addr", mem_addr, 32'h44);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        chk1 ("t5_if_done", if_done, 1'b1);
        chk32("t5_if_rdata_new", if_rdata, 32'hCAFE_F00D);
        mem_ack = 1'b0; if_req = 1'b0;
        step();

        // ---- contention fairness, zero-wait memory ----
        auto_mode = 1'b1; max_wait = 0; resp_cnt = 0;
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h100; d_rmask = 4'hF;
        ngr = 0; exp_streak = 0;
        for (int c = 0; c < 60 && ngr < 10; c++) begin
            step();
            if (mem_ce && resp_cnt == 1) begin
                got_f = (mem_addr == 32'h40);
                if (exp_streak == MAX_D_STREAK) begin
                    exp_f = 1'b1; exp_streak = 0;
                end else begin
                    exp_f = 1'b0; exp_streak++;
                end
                chk1($sformatf("t6_grant%0d_is_fetch", ngr), got_f, exp_f);
                ngr++;
            end
        end
        chk1("t6_grant_count", ngr == 10, 1'b1);
        if_req = 1'b0; d_req = 1'b0;
        repeat (4) step();

        // ---- randomized traffic ----
        max_wait = 3;
        f_granted = 1'b0; d_granted = 1'b0; have_rd = 1'b0; last_rd = '0;
        dg = 0; nf = 0; nd = 0;
        for (int c = 0; c < 1560; c++) begin
            step();
            f_drop = 1'b0; d_drop = 1'b0;
            if (mem_ce && resp_cnt == 1) begin
                if (!mem_addr[7]) begin
                    chk1 ("r_f_grant_req", if_req && !f_granted, 1'b1);
                    chk32("r_f_addr", mem_addr, if_addr);
                    chk1 ("r_f_read", mem_rr && !mem_wr, 1'b1);
                    chk1 ("r_f_fair", dg <= MAX_D_STREAK, 1'b1);
                    f_granted = 1'b1; dg = 0;
                end else begin
                    chk1 ("r_d_grant_req", d_req && !d_granted, 1'b1);
                    chk32("r_d_addr", mem_addr, d_addr);
                    chk1 ("r_d_wr", mem_wr, d_wr);
                    chk1 ("r_d_rr", mem_rr, ~d_wr);
                    chk32("r_d_masks", {24'h0, mem_wmask, mem_rmask}, {24'h0, d_wmask, d_rmask});
                    if (d_wr) chk32("r_d_wdata", mem_wdata, d_wdata);
                    d_granted = 1'b1;
                    if (if_req && !f_granted) dg++;
                end
            end
            if (if_done) begin
                chk1 ("r_f_done_valid", f_granted, 1'b1);
                chk32("r_f_rdata", if_rdata, fpat(int'(if_addr[6:2])));
                chk1 ("r_f_err", err, 1'b0);
                if_req = 1'b0; f_granted = 1'b0; f_drop = 1'b1; nf++;
            end
            if (d_done) begin
                chk1("r_d_done_valid", d_granted, 1'b1);
                chk1("r_d_err", err, 1'b0);
                di = int'(d_addr[7:2]);
                if (d_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (d_wmask[b]) ref_mem[di][8*b +: 8] = d_wdata[8*b +: 8];
                    if (have_rd) chk32("r_d_rdata_kept", d_rdata, last_rd);
                end else begin
                    chk32("r_d_rdata", d_rdata, ref_mem[di]);
                    last_rd = ref_mem[di]; have_rd = 1'b1;
                end
                d_req = 1'b0; d_granted = 1'b0; d_drop = 1'b1; nd++;
            end
            if (c < 1500) begin
                if (!if_req && !f_drop && $urandom_range(0, 3) == 0) begin
                    if_req  = 1'b1;
                    if_addr = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
                end
                if (!d_req && !d_drop && $urandom_range(0, 2) == 0) begin
                    d_req   = 1'b1;
                    d_wr    = 1'($urandom_range(0, 1));
                    d_addr  = {24'h0, 1'b1, 5'($urandom_range(0, 31)), 2'b00};
                    d_wdata = $urandom;
                    d_wmask = 4'($urandom_range(0, 15));
                    d_rmask = 4'($urandom_range(0, 15));
                end
            end
        end
        chk1("r_drained", !if_req && !d_req, 1'b1);
        chk1("r_activity", (nf > 20) && (nd > 20), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between instruction fetch (read-only) and the MEM stage (read/write with byte masks).
- Sequences every access through a request/done handshake and a memory handshake that may insert wait states.
- Generates per-requester stall signals for the pipeline.
- Sits between the fetch unit and the MEM stage on one side and the memory macro on the other.

Parameters:
- MAX_D_STREAK, 4: consecutive data-port grants allowed while if_req is pending before fetch is forced a grant (1..15).
- ACK_TIMEOUT, 16: cycles in a BUSY state without mem_ack before the access is aborted (2..255).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- if_req  input  1  fetch read request; level, held until if_done
- if_addr  input  32  fetch address; stable while if_req=1
- if_done  output  1  one-cycle completion pulse to fetch
- if_rdata  output  32  fetch read data; valid with if_done, held until next if_done
- d_req  input  1  MEM-stage request; level, held until d_done
- d_wr  input  1  1 = write, 0 = read
- d_addr  input  32  data address
- d_wdata  input  32  write data
- d_wmask  input  4  write byte mask
- d_rmask  input  4  read byte mask
- d_done  output  1  one-cycle completion pulse to MEM stage
- d_rdata  output  32  data read result; valid with d_done, held until next d_done
- err  output  1  pulses with if_done/d_done when the access timed out
- mem_ce  output  1  memory chip enable
- mem_wr  output  1  memory write enable
- mem_rr  output  1  memory read enable
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_wmask  output  4  memory write mask
- mem_rmask  output  4  memory read mask
- mem_rdata  input  32  memory read data; valid when mem_ack=1
- mem_ack  input  1  memory completion
- stall_if  output  1  if_req & ~if_done (combinational)
- stall_mem  output  1  d_req & ~d_done (combinational)

Behaviour:
- States are IDLE, BUSY_I, BUSY_D and RESP. All mem_* outputs, done outputs, err, rdata, and the streak and timeout counters are registered.
- Reset (rst=0, any time, including mid-access): state returns to IDLE. All registered outputs, rdata registers and counters clear to 0; the in-flight access is dropped. Stall outputs follow their inputs.
- IDLE arbitration, evaluated every cycle:
  - d_req only: go to BUSY_D.
  - if_req only: go to BUSY_I.
  - Both requesting: data wins unless d_streak == MAX_D_STREAK, in which case fetch wins.
  - Neither requesting: stay in IDLE.
- Streak counter: d_streak increments on each data grant made while if_req=1. It clears on a fetch grant, and on any IDLE cycle with if_req=0.
- Memory drive: on the transition into BUSY_x, mem_* load from the winner's inputs and hold constant for the whole of BUSY_x.
  - Fetch access: mem_ce=1, mem_rr=1, mem_wr=0, mem_rmask=4'hF, mem_wmask=0, mem_wdata=0.
  - Data access: mem_ce=1, mem_wr=d_wr, mem_rr=~d_wr, masks from d_wmask/d_rmask.
- In BUSY_x, mem_ack=1: capture mem_rdata into x_rdata (reads only; writes leave d_rdata unchanged), clear mem_* to 0, go to RESP with x_done=1 for exactly that one RESP cycle.
- Timeout: the counter clears on BUSY entry and increments each BUSY cycle without ack. At ACK_TIMEOUT it aborts: mem_* clear, rdata is unchanged, go to RESP with x_done=1 and err=1.
- RESP lasts exactly one cycle with no arbitration in it, so a request still held during the done cycle is not re-issued. Next state is IDLE.
- Latency: request in IDLE at cycle 0 → mem_ce at cycle 1 → ack at cycle 1+w → done at cycle 2+w. Minimum is 2 cycles; back-to-back accesses take one every 3+w cycles.
- mem_ack outside BUSY is ignored. A request dropped mid-BUSY has no effect; the access completes and done still pulses.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0040, mem_ack on the first BUSY cycle with mem_rdata=0x2402_0005 → mem_ce/mem_rr=1 at cycle 1; if_done=1, if_rdata=0x2402_0005 at cycle 2; stall_if=1 for cycles 0–1.
- Data write with 3 wait states: d_req=1, d_wr=1, d_addr=0x100, d_wdata=0xA5A5_A5A5, d_wmask=4'b0011 → mem_wr=1 and mem_wmask=0011 held for 4 cycles; d_done at cycle 5; d_rdata unchanged.
- Contention fairness with MAX_D_STREAK=4: both requesters continuously pending, 0-wait memory → grant order D,D,D,D,I,D,… with the fetch grant on the 5th access.
- Timeout with ACK_TIMEOUT=16: d_req read, mem_ack never asserted → mem_ce drops after 16 BUSY cycles; d_done=1 and err=1 on the next cycle; d_rdata keeps its previous value.
- Held request, no duplicate: keep d_req=1 through the done cycle and drop it the cycle after → exactly one memory access.
- Async reset mid-access: assert rst=0 during BUSY_D between clock edges → mem_ce=0 and all outputs 0 immediately; after release, the first if_req is granted normally.
